// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE  = 2'd0,
    HZ_RUN   = 2'd1,
    HZ_DRAIN = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  // Saturating increment for the optional performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - E-stage operand forwarding selector for one source register
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_m_i,
  input  logic                      reg_write_w_i,
  output fwd_sel_t                  sel_o
);

  logic hit_m;
  logic hit_w;

  // x0 is hardwired to zero, so a write to it is never a forwarding source.
  assign hit_m = reg_write_m_i && (rd_m_i != '0) && (rs_i == rd_m_i);
  assign hit_w = reg_write_w_i && (rd_w_i != '0) && (rs_i == rd_w_i);

  always_comb begin
    sel_o = FWD_REG;
    if (hit_m) begin
      sel_o = FWD_M;
    end else if (hit_w) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - run/halt sequencer, stall/flush and forwarding control for the 5-stage core
// Optional performance counters enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned DRAIN_CYCLES   = DRAIN_CYCLES_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      trigger_i,
  input  logic                      halt_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic                      RegWriteM_i,
  input  logic                      RegWriteW_i,
  input  logic                      ResultSrcE0_i,
  input  logic                      PCSrcE_i,
  output logic                      StallF_o,
  output logic                      StallD_o,
  output logic                      FlushD_o,
  output logic                      FlushE_o,
  output logic [1:0]                ForwardAE_o,
  output logic [1:0]                ForwardBE_o,
  output logic                      run_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               flush_cnt_o
`endif
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             lw_stall;
  fwd_sel_t         fwd_a, fwd_b;

  fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_i          (Rs1E_i),
    .rd_m_i        (RdM_i),
    .rd_w_i        (RdW_i),
    .reg_write_m_i (RegWriteM_i),
    .reg_write_w_i (RegWriteW_i),
    .sel_o         (fwd_a)
  );

  fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_i          (Rs2E_i),
    .rd_m_i        (RdM_i),
    .rd_w_i        (RdW_i),
    .reg_write_m_i (RegWriteM_i),
    .reg_write_w_i (RegWriteW_i),
    .sel_o         (fwd_b)
  );

  assign lw_stall = ResultSrcE0_i && (RdE_i != '0) &&
                    ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= HZ_IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    StallF_o    = 1'b1;
    StallD_o    = 1'b1;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b1;
    ForwardAE_o = FWD_REG;
    ForwardBE_o = FWD_REG;
    run_o       = 1'b0;
    unique case (state_q)
      HZ_IDLE: begin
        if (trigger_i) begin
          state_d = HZ_RUN;
        end
      end
      HZ_RUN: begin
        StallF_o    = lw_stall;
        StallD_o    = lw_stall;
        FlushD_o    = PCSrcE_i;
        FlushE_o    = lw_stall | PCSrcE_i;
        ForwardAE_o = fwd_a;
        ForwardBE_o = fwd_b;
        run_o       = 1'b1;
        if (halt_i) begin
          state_d     = HZ_DRAIN;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      HZ_DRAIN: begin
        // Fetch frozen, D keeps flowing as bubbles so only bubbles reach E.
        StallD_o    = 1'b0;
        FlushD_o    = 1'b1;
        ForwardAE_o = fwd_a;
        ForwardBE_o = fwd_b;
        if (drain_cnt_q == '0) begin
          state_d = HZ_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = HZ_IDLE;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == HZ_IDLE && trigger_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else if (state_q == HZ_RUN) begin
      if (lw_stall) stall_cnt_d = sat_inc(stall_cnt_q);
      if (PCSrcE_i) flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed plus randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  localparam int DRAIN = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic       clk;
  logic       rst_n;
  logic       trigger, halt;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
  logic       StallF, StallD, FlushD, FlushE, run;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  int     mode = M_IDLE;
  int     drain_left = 0;
  longint m_stalls = 0;
  longint m_flushes = 0;

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .trigger_i     (trigger),
    .halt_i        (halt),
    .Rs1D_i        (Rs1D),
    .Rs2D_i        (Rs2D),
    .Rs1E_i        (Rs1E),
    .Rs2E_i        (Rs2E),
    .RdE_i         (RdE),
    .RdM_i         (RdM),
    .RdW_i         (RdW),
    .RegWriteM_i   (RegWriteM),
    .RegWriteW_i   (RegWriteW),
    .ResultSrcE0_i (ResultSrcE0),
    .PCSrcE_i      (PCSrcE),
    .StallF_o      (StallF),
    .StallD_o      (StallD),
    .FlushD_o      (FlushD),
    .FlushE_o      (FlushE),
    .ForwardAE_o   (ForwardAE),
    .ForwardBE_o   (ForwardBE),
    .run_o         (run)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd_model(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && rs == RdM) return 2;
    if (RegWriteW && RdW != 0 && rs == RdW) return 1;
    return 0;
  endfunction

  function automatic bit lw_model();
    return ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
  endfunction

  task automatic check_all(input string tag);
    bit lw;
    lw = lw_model();
    case (mode)
      M_RUN: begin
        chk({tag, ".StallF"}, StallF, lw);
        chk({tag, ".StallD"}, StallD, lw);
        chk({tag, ".FlushD"}, FlushD, PCSrcE);
        chk({tag, ".FlushE"}, FlushE, lw | PCSrcE);
        chk({tag, ".FwdA"}, ForwardAE, fwd_model(Rs1E));
        chk({tag, ".FwdB"}, ForwardBE, fwd_model(Rs2E));
        chk({tag, ".run"}, run, 1);
      end
      M_DRAIN: begin
        chk({tag, ".StallF"}, StallF, 1);
        chk({tag, ".StallD"}, StallD, 0);
        chk({tag, ".FlushD"}, FlushD, 1);
        chk({tag, ".FlushE"}, FlushE, 1);
        chk({tag, ".FwdA"}, ForwardAE, fwd_model(Rs1E));
        chk({tag, ".FwdB"}, ForwardBE, fwd_model(Rs2E));
        chk({tag, ".run"}, run, 0);
      end
      default: begin
        chk({tag, ".StallF"}, StallF, 1);
        chk({tag, ".StallD"}, StallD, 1);
        chk({tag, ".FlushD"}, FlushD, 0);
        chk({tag, ".FlushE"}, FlushE, 1);
        chk({tag, ".FwdA"}, ForwardAE, 0);
        chk({tag, ".FwdB"}, ForwardBE, 0);
        chk({tag, ".run"}, run, 0);
      end
    endcase
`ifdef HAZARD_PERF_EN
    chk({tag, ".stall_cnt"}, stall_cnt, (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls));
    chk({tag, ".flush_cnt"}, flush_cnt, (m_flushes > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_flushes));
`endif
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    if (!rst_n) begin
      mode = M_IDLE; drain_left = 0; m_stalls = 0; m_flushes = 0;
    end else if (mode == M_IDLE) begin
      if (trigger) begin
        mode = M_RUN; m_stalls = 0; m_flushes = 0;
      end
    end else if (mode == M_RUN) begin
      if (lw_model()) m_stalls++;
      if (PCSrcE) m_flushes++;
      if (halt) begin
        mode = M_DRAIN; drain_left = DRAIN;
      end
    end else begin
      drain_left--;
      if (drain_left == 0) mode = M_IDLE;
    end
  endtask

  task automatic settle(input string tag);
    #4;
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_pipe();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE} = '0;
  endtask

  initial begin
    rst_n = 1'b0; trigger = 1'b0; halt = 1'b0;
    clear_pipe();
    @(posedge clk);
    model_edge();
    #1;
    settle("rst"); tick();
    rst_n = 1'b1;
    settle("idle");
    chk("idle.run_lit", run, 0);
    chk("idle.stall_lit", StallF, 1);
    tick();

    trigger = 1'b1;
    settle("trig"); tick();
    trigger = 1'b0;
    settle("run0");
    chk("run0.run_lit", run, 1);
    chk("run0.stall_lit", StallF, 0);
    tick();

    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    settle("lw");
    chk("lw.stall_lit", StallD, 1);
    chk("lw.flushE_lit", FlushE, 1);
    tick();
    ResultSrcE0 = 1'b0; RdE = 5'd0; Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1'b1;
    settle("lw_after");
    chk("lw_after.fwd_lit", ForwardAE, 2'b01);
    chk("lw_after.stall_lit", StallF, 0);
    tick();
    ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    settle("lw_x0");
    chk("lw_x0.stall_lit", StallF, 0);
    tick();

    clear_pipe();
    Rs1E = 5'd7; RdM = 5'd7; RegWriteM = 1'b1; RdW = 5'd7; RegWriteW = 1'b1;
    settle("fwd_m");
    chk("fwd_m.lit", ForwardAE, 2'b10);
    tick();
    RegWriteM = 1'b0;
    settle("fwd_w");
    chk("fwd_w.lit", ForwardAE, 2'b01);
    tick();
    Rs2E = 5'd0;
    settle("fwd_x0");
    chk("fwd_x0.lit", ForwardBE, 2'b00);
    tick();

    clear_pipe();
    PCSrcE = 1'b1;
    settle("br");
    chk("br.flushD_lit", FlushD, 1);
    chk("br.stallF_lit", StallF, 0);
    tick();
    PCSrcE = 1'b0;
    settle("br_after");
    chk("br_after.flushD_lit", FlushD, 0);
    tick();

    halt = 1'b1; PCSrcE = 1'b1;
    settle("halt"); tick();
    halt = 1'b0; PCSrcE = 1'b0; trigger = 1'b1;
    for (int i = 0; i < DRAIN; i++) begin
      RdM = 5'(i + 1); Rs1E = 5'(i + 1); RegWriteM = 1'b1;
      settle("drain");
      chk("drain.stallF_lit", StallF, 1);
      chk("drain.fwd_lit", ForwardAE, 2'b10);
      tick();
    end
    trigger = 1'b0;
    clear_pipe();
    settle("post_drain");
    chk("post_drain.run_lit", run, 0);
    tick();

    trigger = 1'b1;
    settle("re_trig"); tick();
    trigger = 1'b0; ResultSrcE0 = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
    settle("pre_halt_lw"); tick();
    clear_pipe(); halt = 1'b1;
    settle("halt2"); tick();
    halt = 1'b0;
    settle("drain2a"); tick();
    rst_n = 1'b0;
    settle("drain2b_rst"); tick();
    rst_n = 1'b1;
    settle("after_rst");
    chk("after_rst.stallD_lit", StallD, 1);
`ifdef HAZARD_PERF_EN
    chk("after_rst.stall_cnt_lit", stall_cnt, 0);
    chk("after_rst.flush_cnt_lit", flush_cnt, 0);
`endif
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ResultSrcE0 = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
      settle("perf_lw"); tick();
    end
    clear_pipe();
    for (int i = 0; i < 2; i++) begin
      PCSrcE = 1'b1;
      settle("perf_br"); tick();
    end
    PCSrcE = 1'b0;
    settle("perf_end");
`ifdef HAZARD_PERF_EN
    chk("perf.stall_cnt_lit", stall_cnt, 4);
    chk("perf.flush_cnt_lit", flush_cnt, 2);
`endif
    tick();

    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      trigger     = ($urandom_range(0, 2) == 0);
      halt        = ($urandom_range(0, 7) == 0);
      Rs1D        = 5'($urandom_range(0, 7));
      Rs2D        = 5'($urandom_range(0, 7));
      Rs1E        = 5'($urandom_range(0, 7));
      Rs2E        = 5'($urandom_range(0, 7));
      RdE         = 5'($urandom_range(0, 7));
      RdM         = 5'($urandom_range(0, 7));
      RdW         = 5'($urandom_range(0, 7));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      ResultSrcE0 = 1'($urandom_range(0, 1));
      PCSrcE      = ($urandom_range(0, 3) == 0);
      settle("rand"); tick();
    end

    rst_n = 1'b1; trigger = 1'b1; halt = 1'b1;
    clear_pipe();
    for (int i = 0; i < 12; i++) begin
      settle("held"); tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline controller for the 5-stage core. It sequences run/halt of the pipeline from `trigger`, generates the F/D stall and D/E flush enables, and drives the E-stage forwarding selects. It sits beside the pipeline registers and replaces the constant `en` currently tied to the PC register and the D-stage register.

## Interface
- `REG_ADDR_WIDTH`, default 5: register-address width.
- `DRAIN_CYCLES`, default 3: bubble cycles spent retiring in-flight instructions after halt.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `trigger_i`  in  1  start request; sampled only in IDLE.
- `halt_i`  in  1  halt request from the E stage; sampled only in RUN.
- `Rs1D_i`, `Rs2D_i`  in  REG_ADDR_WIDTH  D-stage source registers.
- `Rs1E_i`, `Rs2E_i`, `RdE_i`  in  REG_ADDR_WIDTH  E-stage source and destination registers.
- `RdM_i`, `RdW_i`  in  REG_ADDR_WIDTH  M- and W-stage destination registers.
- `RegWriteM_i`, `RegWriteW_i`  in  1  register-write enables in M and W.
- `ResultSrcE0_i`  in  1  E-stage instruction is a load (ResultSrcE[0]).
- `PCSrcE_i`  in  1  taken branch or jump resolved in E.
- `StallF_o`, `StallD_o`  out  1  hold the PC register / D pipeline register. Active-high; the PC and D-register enable is `~Stall`.
- `FlushD_o`, `FlushE_o`  out  1  clear the D / E pipeline register to a bubble.
- `ForwardAE_o`, `ForwardBE_o`  out  2  SrcA/SrcB select: 00 register file, 01 Result (W), 10 ALUResultM.
- `run_o`  out  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - Outputs: StallF=StallD=1, FlushD=0, FlushE=1, Forward*=00, run_o=0.
  - Transition: `trigger_i`=1 → RUN.
- **RUN**
  - lwStall = ResultSrcE0_i & RdE_i≠0 & (Rs1D_i==RdE_i | Rs2D_i==RdE_i).
  - StallF=StallD=lwStall; FlushD=PCSrcE_i; FlushE=lwStall|PCSrcE_i.
  - lwStall and PCSrcE_i are mutually exclusive by construction. If both are asserted, both rules still apply; no extra priority logic is added.
  - Transition: `halt_i`=1 → DRAIN with drain_cnt loaded to DRAIN_CYCLES-1. Halt takes priority over PCSrcE_i for the next state; in the halt cycle itself the RUN outputs above still apply.
- **DRAIN**
  - Outputs: StallF=1, StallD=0, FlushD=1, FlushE=1, so only bubbles enter E.
  - Forwarding stays active so the retiring instructions see correct operands.
  - drain_cnt decrements each cycle; at 0 → IDLE.
- **Forwarding (RUN and DRAIN)**
  - ForwardAE=10 if RegWriteM_i & RdM_i≠0 & Rs1E_i==RdM_i.
  - Otherwise 01 if RegWriteW_i & RdW_i≠0 & Rs1E_i==RdW_i.
  - Otherwise 00.
  - M takes priority over W. ForwardBE uses Rs2E_i with the same rules.
- Ignored inputs: `trigger_i` outside IDLE; `halt_i` outside RUN.
- Register x0 never causes a stall or a forward.

## Timing
- Reset, while rst_ni=0 at an edge: state=IDLE, drain_cnt=0. From the next cycle the outputs take their IDLE values.
- Outputs are combinational from the registered state and the current inputs. No output is registered.
- **Start:** trigger_i=1 at edge N makes state=RUN from N. The first PC advance occurs at edge N+1.
- **Load-use:** lwStall holds F and D and inserts one bubble in E for exactly one cycle. The following cycle forwards from W (01).
- **Halt:** halt_i at edge N gives DRAIN for cycles N..N+DRAIN_CYCLES-1 and IDLE from edge N+DRAIN_CYCLES.
- **Reset mid-DRAIN or mid-RUN:** return to IDLE at the next edge, with no partial drain.
- **trigger_i and halt_i held high:** RUN → DRAIN → IDLE → RUN cycles repeatedly. This is legal.

## Configuration
- Macro: `HAZARD_PERF_EN`.
- Defined:
  - Adds outputs `stall_cnt_o` [31:0] (RUN cycles with lwStall) and `flush_cnt_o` [31:0] (RUN cycles with PCSrcE_i).
  - Both counters saturate at 0xFFFFFFFF.
  - Both are zero on reset and are cleared on the IDLE→RUN transition.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `pipe_pkg`:
  - `hz_state_t` enum: HZ_IDLE, HZ_RUN, HZ_DRAIN.
  - `fwd_sel_t` [1:0] with FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - Default DRAIN_CYCLES constant.
- Sub-module `fwd_unit`: combinational forwarding selector taking one source register, RdM, RdW, RegWriteM and RegWriteW, and returning `fwd_sel_t`. It is instantiated twice, once for A and once for B.

## Test plan
- **Reset and start:** rst_ni=0 for 2 cycles, then trigger_i=0 → StallF=StallD=FlushE=1, run_o=0. Pulse trigger_i → run_o=1 and stalls drop in the same cycle.
- **Load-use:** RUN with ResultSrcE0_i=1, RdE_i=5, Rs1D_i=5 → StallF=StallD=FlushE=1 for exactly one cycle. Repeat with RdE_i=0 → no stall.
- **Forward priority:** Rs1E_i=7, RdM_i=7, RegWriteM_i=1, RdW_i=7, RegWriteW_i=1 → ForwardAE_o=10. Drop RegWriteM_i → 01. Set Rs2E_i=0 with the same Rd values → ForwardBE_o=00.
- **Taken branch:** PCSrcE_i=1 in RUN → FlushD_o=FlushE_o=1 and StallF_o=0 for that cycle only.
- **Halt drain:** halt_i=1 at edge N with PCSrcE_i=1 → DRAIN for 3 cycles (StallF=1, FlushD=1), forwarding still tracks RdM/RdW, then IDLE. trigger_i during DRAIN is ignored.
- **Reset mid-drain, with HAZARD_PERF_EN:** assert rst_ni=0 in the second DRAIN cycle → IDLE and counters at 0. Then 4 load-use cycles and 2 taken branches → stall_cnt_o=4, flush_cnt_o=2.
